// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two bypassed read ports, busy scoreboard.
// Optional REGFILE_MP_ZERO_REG_EN hardwires register 0 to zero and makes it unreservable.
module regfile_mp #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    reservenum,
    input  logic             reserve,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [CW-1:0]    busy_count
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            busy_nxt;
    logic [CW-1:0]              cnt_nxt;
    logic                       we;
    logic                       rs;

`ifdef REGFILE_MP_ZERO_REG_EN
    assign we = write   && (writenum   != '0);
    assign rs = reserve && (reservenum != '0);
`else
    assign we = write;
    assign rs = reserve;
`endif

    // Release first, then reserve, so a same-cycle reserve of the written register wins.
    always_comb begin
        busy_nxt = busy;
        if (we) busy_nxt[writenum] = 1'b0;
        if (rs) busy_nxt[reservenum] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs       <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (we) regs[writenum] <= data_in;
            busy       <= busy_nxt;
            busy_count <= cnt_nxt;
        end
    end

    assign data_out_a = (we && readnum_a == writenum) ? data_in : regs[readnum_a];
    assign data_out_b = (we && readnum_b == writenum) ? data_in : regs[readnum_b];
    assign busy_a     = busy[readnum_a];
    assign busy_b     = busy[readnum_b];
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] data_in;
    logic [2:0]  writenum, reservenum, readnum_a, readnum_b;
    logic        write, reserve;
    logic [15:0] data_out_a, data_out_b;
    logic        busy_a, busy_b;
    logic [3:0]  busy_count;

    typedef struct {
        string       name;
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic done   = 1'b0;

    regfile_mp #(.WIDTH(16), .AW(3), .CW(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum),
        .write(write), .reservenum(reservenum), .reserve(reserve),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [15:0] da, input logic [15:0] db,
                              input logic ba, input logic bb, input logic [3:0] cnt);
        exp_t e;
        e.name = n; e.da = da; e.db = db; e.ba = ba; e.bb = bb; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    // Monitor: outputs are combinational, so every queued entry is checked mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.name, ".data_a"}, data_out_a, e.da);
            cmp({e.name, ".data_b"}, data_out_b, e.db);
            cmp({e.name, ".busy_a"}, 16'(busy_a), 16'(e.ba));
            cmp({e.name, ".busy_b"}, 16'(busy_b), 16'(e.bb));
            cmp({e.name, ".count"},  16'(busy_count), 16'(e.cnt));
        end
    end

    initial begin
        reset_n = 1'b0; data_in = '0; writenum = '0; write = 1'b0;
        reservenum = '0; reserve = 1'b0; readnum_a = '0; readnum_b = '0;
        cyc(); cyc();
        reset_n = 1'b1;

        // Reset state on every address
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i); readnum_b = 3'(7 - i);
            expect_out("rst_read", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
            cyc();
        end

        // Write R3, bypass during the write, then read on both ports
        write = 1'b1; writenum = 3'd3; data_in = 16'hA5A5; readnum_a = 3'd3; readnum_b = 3'd0;
        expect_out("wr3_bypass", 16'hA5A5, 16'h0, 1'b0, 1'b0, 4'd0);
        cyc();
        write = 1'b0; readnum_b = 3'd3;
        expect_out("rd3_both", 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 4'd0);
        cyc();
        write = 1'b1; writenum = 3'd5; data_in = 16'h1234; readnum_b = 3'd5;
        expect_out("wr5_bypass_b", 16'hA5A5, 16'h1234, 1'b0, 1'b0, 4'd0);
        cyc();
        write = 1'b0;
        expect_out("rd5_after", 16'hA5A5, 16'h1234, 1'b0, 1'b0, 4'd0);
        cyc();

        // Reserve R2, R6, R2 again
        reserve = 1'b1; reservenum = 3'd2; readnum_a = 3'd2; readnum_b = 3'd6;
        expect_out("rsv2_same_cyc", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
        cyc();
        reservenum = 3'd6;
        expect_out("rsv2_done", 16'h0, 16'h0, 1'b1, 1'b0, 4'd1);
        cyc();
        reservenum = 3'd2;
        expect_out("rsv6_done", 16'h0, 16'h0, 1'b1, 1'b1, 4'd2);
        cyc();
        reserve = 1'b0;
        expect_out("rsv2_again", 16'h0, 16'h0, 1'b1, 1'b1, 4'd2);
        cyc();

        // Write back R6 releases it; flags show registered state until the edge
        write = 1'b1; writenum = 3'd6; data_in = 16'h0001; readnum_a = 3'd6; readnum_b = 3'd2;
        expect_out("wb6_same_cyc", 16'h0001, 16'h0, 1'b1, 1'b1, 4'd2);
        cyc();
        write = 1'b0;
        expect_out("wb6_released", 16'h0001, 16'h0, 1'b0, 1'b1, 4'd1);
        cyc();

        // Reserve and write the same register: reserve wins, data lands
        write = 1'b1; writenum = 3'd4; data_in = 16'hBEEF; reserve = 1'b1; reservenum = 3'd4;
        readnum_a = 3'd4; readnum_b = 3'd3;
        expect_out("rsvwr4_same_cyc", 16'hBEEF, 16'hA5A5, 1'b0, 1'b0, 4'd1);
        cyc();
        write = 1'b0; reserve = 1'b0;
        expect_out("rsvwr4_after", 16'hBEEF, 16'hA5A5, 1'b1, 1'b0, 4'd2);
        cyc();

        // Reserve everything, then reset with a concurrent write
        reserve = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reservenum = 3'(i);
            cyc();
        end
        reserve = 1'b0; readnum_a = 3'd1; readnum_b = 3'd7;
`ifdef REGFILE_MP_ZERO_REG_EN
        expect_out("all_reserved", 16'h0, 16'h0, 1'b1, 1'b1, 4'd7);
`else
        expect_out("all_reserved", 16'h0, 16'h0, 1'b1, 1'b1, 4'd8);
`endif
        cyc();
        reset_n = 1'b0; write = 1'b1; writenum = 3'd1; data_in = 16'hFFFF;
        readnum_a = 3'd2; readnum_b = 3'd2;
        cyc();
        reset_n = 1'b1; write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i); readnum_b = 3'd1;
            expect_out("post_reset", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
            cyc();
        end

        // Register 0 behaviour
        write = 1'b1; writenum = 3'd0; data_in = 16'hFFFF; reserve = 1'b1; reservenum = 3'd0;
        readnum_a = 3'd0; readnum_b = 3'd1;
`ifdef REGFILE_MP_ZERO_REG_EN
        expect_out("r0_during", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
        cyc();
        write = 1'b0; reserve = 1'b0;
        expect_out("r0_after", 16'h0, 16'h0, 1'b0, 1'b0, 4'd0);
`else
        expect_out("r0_during", 16'hFFFF, 16'h0, 1'b0, 1'b0, 4'd0);
        cyc();
        write = 1'b0; reserve = 1'b0;
        expect_out("r0_after", 16'hFFFF, 16'h0, 1'b1, 1'b0, 4'd1);
`endif
        cyc();

        for (int t = 0; t < 10 && q.size() > 0; t++) cyc();
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: run not complete at %0t, expected completion", $time);
            $fatal(1);
        end
    end
endmodule
